digit_uart_tx: RTL
==================

// Module: digit_uart_tx
// PURPOSE
//  Reader side of the 8-digit hex entry buffer. On a send request it snapshots the
//  buffer and transmits it over the board UART transmit port (txdata/txclk/txready),
//  one ASCII byte per digit, most significant digit (digits[7]) first, with optional CR LF.
//  Sits in top beside the key-entry logic and the seven_seg decoder.
// PARAMETERS
//  SEND_EOL     1   1: append 8'h0D, 8'h0A after the digits (10 bytes); 0: 8 bytes only
//  ACK_TIMEOUT  4   max CLK cycles to wait for txready to fall after a txclk strobe (>=1)
// PORTS
//  CLK        in   1       system clock (hz100 at top)
//  NRST       in   1       asynchronous active-low reset
//  send       in   1       send request, level (pushbutton); rising edge starts a frame
//  digits     in   [7:0][3:0] hex digit buffer; sampled only at frame start
//  txready    in   1       UART can accept a byte when 1
//  txdata     out  8       byte presented to UART
//  txclk      out  1       one-cycle load strobe; UART latches txdata while high
//  busy       out  1       1 from frame start until DONE state is left
//  done       out  1       one-cycle pulse after last byte accepted
// BEHAVIOUR
//  Reset (async, NRST=0): state=IDLE, txdata=8'h00, txclk=0, busy=0, done=0, idx=0,
//   snapshot=0, send edge register=0. Reset mid-frame aborts; no further strobes.
//  Edge detect: send_q <= send; start = send & ~send_q & (state==IDLE).
//   Edges while busy are ignored (not queued). Held send produces one frame only.
//  Encoding: nibble 0-9 -> 8'h30+n; A-F -> 8'h41+(n-10). Uppercase only.
//  Byte idx 0..7 = digits[7-idx] of snapshot; idx 8,9 = 8'h0D,8'h0A when SEND_EOL.
//  LAST = SEND_EOL ? 9 : 7; idx is 4 bits.
//  FSM (all outputs registered or decoded from state register):
//   IDLE     : start -> snapshot<=digits, idx<=0, WAIT_RDY.
//   WAIT_RDY : txready=1 -> txdata<=byte(idx), STROBE. Waits indefinitely.
//   STROBE   : txclk=1 exactly this cycle; txdata stable -> WAIT_ACK, timer<=0.
//   WAIT_ACK : txready=0 or timer==ACK_TIMEOUT-1 -> (idx==LAST ? DONE : idx++, WAIT_RDY);
//              else timer++. Prevents double-send if txready lags.
//   DONE     : done=1 one cycle -> IDLE.
//  busy = (state != IDLE). txdata holds last byte after frame (not cleared).
//  Latency: start edge seen at cycle t -> first txclk at t+2 if txready already 1.
//  Min frame time, txready dropping immediately: per byte 3 cycles (RDY,STROBE,ACK).
//  digits changing during frame has no effect (snapshot).
//  txready stuck 1: each byte advances after ACK_TIMEOUT cycles in WAIT_ACK.
//  txready stuck 0: FSM parks in WAIT_RDY, busy=1, txclk=0.
// STRUCTURE
//  Package digit_tx_pkg: typedef enum logic [2:0] {IDLE,WAIT_RDY,STROBE,WAIT_ACK,DONE}
//   tx_state_t; localparams ASCII_0=8'h30, ASCII_A=8'h41, ASCII_CR=8'h0D, ASCII_LF=8'h0A;
//   function hex_to_ascii(logic [3:0]) -> logic [7:0].
//  One sub-module: rise_detect (CLK, NRST, in, pulse) for the send edge.
//  Single always_ff for state/idx/timer/snapshot/txdata, always_comb for next-state.
// TESTING
//  1 digits=32'hDEAD_0159, SEND_EOL=1, UART model drops txready 1 cycle after txclk for
//    2 cycles -> bytes 44 45 41 44 30 31 35 39 0D 0A in order, exactly 10 txclk, one done.
//  2 SEND_EOL=0, digits=32'h0000_00FF -> 30x6, 46 46; 8 strobes; busy falls after done.
//  3 send held high 50 cycles, and re-pulsed mid-frame -> exactly one frame transmitted;
//    new edge after IDLE starts second frame.
//  4 change digits to 32'h1111_1111 after first strobe -> rest of frame uses snapshot.
//  5 txready held 0 at start -> no txclk, busy=1; raise txready -> first strobe 1 cycle later.
//    txready stuck 1, ACK_TIMEOUT=4 -> strobes spaced 6 cycles, no duplicates per byte.
//  6 assert NRST=0 after 3rd byte -> txclk/busy/done/txdata=0 same cycle; after release
//    no strobes until new send edge; next frame starts from idx 0.

Source files
------------

// File: rtl/digit_uart_tx_pkg.sv
// rtl/digit_uart_tx_pkg.sv - shared types, ASCII constants and hex encoder for digit_uart_tx
package digit_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        STROBE,
        WAIT_ACK,
        DONE
    } tx_state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Uppercase hex only
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return ASCII_0 + {4'h0, n};
        end
        return ASCII_A + {4'h0, n - 4'd10};
    endfunction

endpackage

// File: rtl/digit_uart_tx_if.sv
// rtl/digit_uart_tx_if.sv - send request, digit buffer and UART transmit port bundle
interface digit_uart_tx_if;
    logic             send;
    logic [7:0][3:0]  digits;
    logic             txready;
    logic [7:0]       txdata;
    logic             txclk;
    logic             busy;
    logic             done;

    modport master (output send, digits, txready, input txdata, txclk, busy, done);
    modport slave  (input send, digits, txready, output txdata, txclk, busy, done);
endinterface

// File: rtl/digit_uart_tx_rise_detect.sv
// rtl/digit_uart_tx_rise_detect.sv - rising-edge pulse from a level input
module rise_detect (
    input  logic CLK,
    input  logic NRST,
    input  logic in,
    output logic pulse
);
    logic in_q;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;
endmodule

// File: rtl/digit_uart_tx.sv
// rtl/digit_uart_tx.sv - snapshots the hex digit buffer and sends it as ASCII over the UART port
module digit_uart_tx
    import digit_tx_pkg::*;
#(
    parameter bit SEND_EOL    = 1'b1,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic          CLK,
    input  logic          NRST,
    digit_uart_tx_if.slave bus
);
    localparam logic [3:0] LAST = SEND_EOL ? 4'd9 : 4'd7;
    localparam int         TW   = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(ACK_TIMEOUT - 1);

    tx_state_t       state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0][3:0] snap_q, snap_d;
    logic [7:0]      txdata_q, txdata_d;
    logic            send_rise;
    logic            start;
    logic [7:0]      cur_byte;

    rise_detect u_send_edge (
        .CLK   (CLK),
        .NRST  (NRST),
        .in    (bus.send),
        .pulse (send_rise)
    );

    assign start = send_rise && (state_q == IDLE);

    // Digits go out most significant first, then optional CR LF
    always_comb begin
        cur_byte = ASCII_LF;
        if (idx_q < 4'd8) begin
            cur_byte = hex_to_ascii(snap_q[3'd7 - idx_q[2:0]]);
        end else if (idx_q == 4'd8) begin
            cur_byte = ASCII_CR;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        snap_d   = snap_q;
        txdata_d = txdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = bus.digits;
                    idx_d   = 4'd0;
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (bus.txready) begin
                    txdata_d = cur_byte;
                    state_d  = STROBE;
                end
            end
            STROBE: begin
                timer_d = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                // Timeout keeps a lagging txready from stalling or double-sending a byte
                if (!bus.txready || timer_q == TIMER_MAX) begin
                    if (idx_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = WAIT_RDY;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q  <= IDLE;
            idx_q    <= 4'd0;
            timer_q  <= '0;
            snap_q   <= '0;
            txdata_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            snap_q   <= snap_d;
            txdata_q <= txdata_d;
        end
    end

    assign bus.txdata = txdata_q;
    assign bus.txclk  = (state_q == STROBE);
    assign bus.done   = (state_q == DONE);
    assign bus.busy   = (state_q != IDLE);
endmodule
